// File: rtl/dmem_ctrl_if.sv
// Bus bundle for the data-memory controller.
// Ports:
//   p0_*  retire port: stores (mask/data) and held-level loads with tagged response
//   p1_*  aux req/gnt port (debug / program loader)
//   mem_* single-ported synchronous data RAM
//   misalign_err  one-cycle pulse when an access is dropped
// Modports: slave = controller side, master = client/RAM side.
interface dmem_ctrl_if #(
   parameter int MEM_DEPTH = 4096
);
   localparam int AW = $clog2(MEM_DEPTH);

   logic [3:0]    p0_wr_en;
   logic          p0_rd_en;
   logic [31:0]   p0_addr;
   logic [31:0]   p0_data;
   logic          p0_valid;
   logic [AW-1:0] p0_valid_addr;
   logic [31:0]   p0_rdata;

   logic          p1_req;
   logic          p1_we;
   logic [31:0]   p1_addr;
   logic [31:0]   p1_wdata;
   logic [3:0]    p1_wstrb;
   logic          p1_gnt;
   logic          p1_rvalid;
   logic [31:0]   p1_rdata;

   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-3:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic          misalign_err;

   modport slave (
      input  p0_wr_en, p0_rd_en, p0_addr, p0_data,
      output p0_valid, p0_valid_addr, p0_rdata,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_wstrb,
      output p1_gnt, p1_rvalid, p1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output misalign_err
   );

   modport master (
      output p0_wr_en, p0_rd_en, p0_addr, p0_data,
      input  p0_valid, p0_valid_addr, p0_rdata,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_wstrb,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  misalign_err
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates one sync RAM between retire (p0) and aux (p1).
// Ports: clk, rst (async, active-high), bus (dmem_ctrl_if.slave: p0, p1, RAM, misalign_err).
module dmem_ctrl #(
   parameter int MEM_DEPTH    = 4096,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   dmem_ctrl_if.slave bus
);
   localparam int AW   = $clog2(MEM_DEPTH);
   localparam int LW   = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
   localparam int LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
   localparam int SW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, RD_BUSY, RESP} state_t;
   // A single-cycle RAM skips the wait state entirely.
   localparam state_t FIRST = (RD_LATENCY == 1) ? RESP : RD_BUSY;

   state_t        state, state_nx;
   logic [LW-1:0] lat_cnt, lat_cnt_nx;
   logic [SW-1:0] starve_cnt;
   logic          owner, owner_nx;
   logic [AW-1:0] cap_addr, cap_addr_nx;
   logic          cap_oor, cap_oor_nx;

   logic          p0_wr, p0_oor, p0_wr_bad, starving;
   logic [6:0]    we_sh;
   logic [31:0]   wd_sh;
   logic          unused_bits;

   logic          p0_valid, p1_gnt, p1_rvalid, mem_en, err;
   logic [AW-1:0] p0_valid_addr;
   logic [31:0]   p0_rdata, p1_rdata, mem_wdata;
   logic [3:0]    mem_we;
   logic [AW-3:0] mem_addr;

   // Widened mask shift: anything landing above lane 3 straddles a word.
   assign we_sh     = {3'b000, bus.p0_wr_en} << bus.p0_addr[1:0];
   assign wd_sh     = bus.p0_data << {bus.p0_addr[1:0], 3'b000};
   assign p0_wr     = |bus.p0_wr_en;
   assign p0_oor    = |bus.p0_addr[31:AW];
   assign p0_wr_bad = p0_oor | (|we_sh[6:4]);
   assign starving  = (starve_cnt == LIM);
   assign unused_bits = ^bus.p1_addr[31:AW];

   always_comb begin
      state_nx      = state;
      lat_cnt_nx    = lat_cnt;
      owner_nx      = owner;
      cap_addr_nx   = cap_addr;
      cap_oor_nx    = cap_oor;
      p0_valid      = 1'b0;
      p0_valid_addr = '0;
      p0_rdata      = '0;
      p1_gnt        = 1'b0;
      p1_rvalid     = 1'b0;
      p1_rdata      = '0;
      mem_en        = 1'b0;
      mem_we        = '0;
      mem_addr      = '0;
      mem_wdata     = '0;
      err           = 1'b0;
      if (!rst) begin
         p1_gnt = (state == IDLE) && !p0_wr && bus.p1_req &&
                  (!bus.p0_rd_en || starving);
         // Retire stores bypass the FSM; p1 and p0 reads yield to them.
         if (p0_wr) begin
            if (p0_wr_bad) begin
               err = 1'b1;
            end else begin
               mem_en    = 1'b1;
               mem_we    = we_sh[3:0];
               mem_addr  = bus.p0_addr[AW-1:2];
               mem_wdata = wd_sh;
            end
         end
         case (state)
            IDLE: begin
               if (p1_gnt) begin
                  if (|bus.p1_addr[1:0]) begin
                     err = 1'b1;
                  end else if (bus.p1_we) begin
                     mem_en    = |bus.p1_wstrb;
                     mem_we    = bus.p1_wstrb;
                     mem_addr  = bus.p1_addr[AW-1:2];
                     mem_wdata = bus.p1_wdata;
                  end else begin
                     mem_en      = 1'b1;
                     mem_addr    = bus.p1_addr[AW-1:2];
                     owner_nx    = 1'b1;
                     cap_addr_nx = bus.p1_addr[AW-1:0];
                     cap_oor_nx  = 1'b0;
                     lat_cnt_nx  = '0;
                     state_nx    = FIRST;
                  end
               end else if (!p0_wr && bus.p0_rd_en) begin
                  // Out-of-range loads still walk the FSM so the ROB
                  // head gets a (zero) response.
                  owner_nx    = 1'b0;
                  cap_addr_nx = bus.p0_addr[AW-1:0];
                  cap_oor_nx  = p0_oor;
                  lat_cnt_nx  = '0;
                  state_nx    = FIRST;
                  if (p0_oor) begin
                     err = 1'b1;
                  end else begin
                     mem_en   = 1'b1;
                     mem_addr = bus.p0_addr[AW-1:2];
                  end
               end
            end
            RD_BUSY: begin
               if (lat_cnt == LW'(LAST)) state_nx = RESP;
               else lat_cnt_nx = lat_cnt + LW'(1);
            end
            RESP: begin
               state_nx = IDLE;
               if (owner) begin
                  p1_rvalid = 1'b1;
                  p1_rdata  = bus.mem_rdata;
               end else if (bus.p0_rd_en) begin
                  // A dropped rd_en here means the load was flushed.
                  p0_valid      = 1'b1;
                  p0_valid_addr = cap_addr;
                  p0_rdata      = cap_oor ? 32'h0 :
                                  bus.mem_rdata >> {cap_addr[1:0], 3'b000};
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         owner      <= 1'b0;
         cap_addr   <= '0;
         cap_oor    <= 1'b0;
         starve_cnt <= '0;
      end else begin
         state    <= state_nx;
         lat_cnt  <= lat_cnt_nx;
         owner    <= owner_nx;
         cap_addr <= cap_addr_nx;
         cap_oor  <= cap_oor_nx;
         if (p1_gnt) starve_cnt <= '0;
         else if (bus.p1_req && starve_cnt != LIM) starve_cnt <= starve_cnt + SW'(1);
      end
   end

   assign bus.p0_valid      = p0_valid;
   assign bus.p0_valid_addr = p0_valid_addr;
   assign bus.p0_rdata      = p0_rdata;
   assign bus.p1_gnt        = p1_gnt;
   assign bus.p1_rvalid     = p1_rvalid;
   assign bus.p1_rdata      = p1_rdata;
   assign bus.mem_en        = mem_en;
   assign bus.mem_we        = mem_we;
   assign bus.mem_addr      = mem_addr;
   assign bus.mem_wdata     = mem_wdata;
   assign bus.misalign_err  = err;
endmodule
